// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Resolves conditional branches, jal and jalr against a PC
//                delayed to line up with the decode strobes. It produces a
//                registered redirect (enable, target, link) one edge after
//                the strobe.
//                Optional feature macro: JB_MISALIGN_EXC_EN. In byte mode it
//                flags taken targets that are not word aligned and suppresses
//                the redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int PC_DELAY     = 3,
  parameter int PC_WORD_ADDR = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] src1_value,
  input  logic [XLEN-1:0] src2_value,
  input  logic [XLEN-1:0] imm,
  input  logic            beq,
  input  logic            bne,
  input  logic            blt,
  input  logic            bge,
  input  logic            bltu,
  input  logic            bgeu,
  input  logic            jal,
  input  logic            jalr,
  input  logic            stall,
  input  logic            flush,
  output logic            jb_enable,
  output logic [XLEN-1:0] jb_target_pc,
  output logic [XLEN-1:0] jb_link,
  output logic            misalign_exc
);

  // --------------------------------------------------------------------------
  // PC delay line: entry 0 is the newest, entry PC_DELAY-1 is the oldest (D).
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] pc_dly_q [PC_DELAY];
  logic [XLEN-1:0] w_d_pc;

  assign w_d_pc = pc_dly_q[PC_DELAY-1];

  // Shift the fetch PC in on every non-stalled edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PC_DELAY; i++) begin
        pc_dly_q[i] <= '0;
      end
    end else if (!stall) begin
      pc_dly_q[0] <= pc;
      for (int i = 1; i < PC_DELAY; i++) begin
        pc_dly_q[i] <= pc_dly_q[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Comparators shared by all conditional branches.
  // --------------------------------------------------------------------------
  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;

  assign w_eq   = (src1_value == src2_value);
  assign w_lt_s = ($signed(src1_value) < $signed(src2_value));
  assign w_lt_u = (src1_value < src2_value);

  // --------------------------------------------------------------------------
  // Strobe priority: beq > bne > blt > bge > bltu > bgeu > jal > jalr.
  // Only jalr selects the register-relative target.
  // --------------------------------------------------------------------------
  logic w_taken;
  logic w_sel_jalr;

  // Pick the highest-priority strobe and evaluate its condition.
  always_comb begin
    w_taken    = 1'b0;
    w_sel_jalr = 1'b0;
    if (beq) begin
      w_taken = w_eq;
    end else if (bne) begin
      w_taken = !w_eq;
    end else if (blt) begin
      w_taken = w_lt_s;
    end else if (bge) begin
      w_taken = !w_lt_s;
    end else if (bltu) begin
      w_taken = w_lt_u;
    end else if (bgeu) begin
      w_taken = !w_lt_u;
    end else if (jal) begin
      w_taken = 1'b1;
    end else if (jalr) begin
      w_taken    = 1'b1;
      w_sel_jalr = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Address arithmetic. In word mode the PC counts 32-bit words, so the byte
  // offset is scaled down (keeping its sign) and the jalr byte address is
  // converted to a word address.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_off;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_jalr_tgt;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_link_inc;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_link;
  logic            w_misalign;

  assign w_jalr_sum = src1_value + imm;

  if (PC_WORD_ADDR != 0) begin : g_word
    assign w_off      = $signed(imm) >>> 2;
    assign w_jalr_tgt = (w_jalr_sum & ~XLEN'(1)) >> 2;
    assign w_link_inc = XLEN'(1);
    // Word addresses are always aligned; no exception is possible.
    assign w_misalign = 1'b0;
  end else begin : g_byte
    assign w_off      = imm;
    assign w_jalr_tgt = w_jalr_sum & ~XLEN'(1);
    assign w_link_inc = XLEN'(4);
`ifdef JB_MISALIGN_EXC_EN
    assign w_misalign = w_taken && (w_target[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif
  end

  // Branch and jal targets wrap modulo 2^XLEN.
  assign w_br_tgt = w_d_pc + w_off;
  assign w_target = w_sel_jalr ? w_jalr_tgt : w_br_tgt;
  assign w_link   = w_d_pc + w_link_inc;

  // --------------------------------------------------------------------------
  // Output registers.
  // --------------------------------------------------------------------------
  logic            jb_enable_q;
  logic            jb_enable_d;
  logic            misalign_q;
  logic            misalign_d;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] link_q;

  // A misaligned taken target raises the exception instead of redirecting.
  assign jb_enable_d = w_taken && !w_misalign;
  assign misalign_d  = w_misalign;

  // Flush kills the result even while stalled; target/link only follow stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jb_enable_q <= 1'b0;
      misalign_q  <= 1'b0;
      target_q    <= '0;
      link_q      <= '0;
    end else begin
      if (flush) begin
        jb_enable_q <= 1'b0;
        misalign_q  <= 1'b0;
      end else if (!stall) begin
        jb_enable_q <= jb_enable_d;
        misalign_q  <= misalign_d;
      end
      if (!stall) begin
        target_q <= w_target;
        link_q   <= w_link;
      end
    end
  end

  assign jb_enable    = jb_enable_q;
  assign misalign_exc = misalign_q;
  assign jb_target_pc = target_q;
  assign jb_link      = link_q;

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of PC, operands, immediate and targets.
REQ-002 SHALL have parameter PC_DELAY, default 3, legal range 1..8: number of cycles the PC is delayed to align with the decode strobes.
REQ-003 SHALL have parameter PC_WORD_ADDR, default 1: 1 means the PC counts 32-bit words, 0 means the PC counts bytes.
REQ-004 SHALL use one clock, clk, and one reset, reset_n, which is asynchronous and active-low.
REQ-005 SHALL have these ports, with clock and reset first:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- pc  in  XLEN  fetch PC
- src1_value  in  XLEN  rs1 operand
- src2_value  in  XLEN  rs2 operand
- imm  in  XLEN  sign-extended byte offset
- beq, bne, blt, bge, bltu, bgeu, jal, jalr  in  1 each  decode strobes
- stall  in  1  freeze the unit
- flush  in  1  kill the result
- jb_enable  out  1  redirect valid
- jb_target_pc  out  XLEN  redirect PC
- jb_link  out  XLEN  return address
- misalign_exc  out  1  misaligned-target exception

Function
REQ-006 SHALL keep a PC delay line of PC_DELAY registers; when stall=0, each posedge shifts pc into the line; D denotes the oldest entry, which is the pc sampled PC_DELAY active edges earlier.
REQ-007 SHALL register all outputs, giving a latency of one edge from the strobe to the outputs.
REQ-008 SHALL resolve simultaneous strobes in this fixed priority: beq > bne > blt > bge > bltu > bgeu > jal > jalr.
REQ-009 SHALL compute taken as follows:
- beq: equal
- bne: not equal
- blt / bge: signed compare
- bltu / bgeu: unsigned compare
- jal / jalr: always taken
- no strobe: taken=0
REQ-010 SHALL compute the byte offset OFF as follows: in byte mode, OFF=imm; in word mode, OFF=imm arithmetically shifted right by 2.
REQ-011 SHALL compute the target for branches and jal as D+OFF, with modulo 2^XLEN wrap-around.
REQ-012 SHALL compute the jalr target in byte mode as (src1_value+imm) with bit 0 cleared, and in word mode as that value logically shifted right by 2.
REQ-013 SHALL compute jb_link as D+4 in byte mode and D+1 in word mode.
REQ-014 SHALL update jb_target_pc and jb_link every non-stalled edge, independent of taken.
REQ-015 SHALL assert jb_enable for exactly one cycle per taken strobe.
REQ-016 SHALL, when stall=1, hold the delay line and all output registers unchanged.
REQ-017 SHALL, when flush=1, clear jb_enable and misalign_exc at the next edge; flush overrides stall and any strobe; the delay line still shifts unless stall=1.

Reset
REQ-018 SHALL, while reset_n=0, clear all delay-line entries, jb_enable, jb_target_pc, jb_link and misalign_exc to 0.
REQ-019 SHALL, on reset asserted mid-operation, clear any in-flight result immediately, with no redirect after release until a new strobe.

Configuration
REQ-020 SHALL, when JB_MISALIGN_EXC_EN is defined, in byte mode: a taken resolve whose target bits [1:0] are nonzero sets misalign_exc=1 for one cycle, forces jb_enable=0, and leaves jb_target_pc holding the faulting target.
REQ-021 SHALL, when JB_MISALIGN_EXC_EN is defined, in word mode: keep misalign_exc at 0.
REQ-022 SHALL, when JB_MISALIGN_EXC_EN is undefined, tie misalign_exc to 0 and leave jb_enable unaffected by alignment.

Verification (defaults: XLEN=32, PC_DELAY=3, PC_WORD_ADDR=1 unless stated)
REQ-023 SHALL cover: pc=0x100,0x101,0x102,0x103 on four edges; beq with src1=src2=5, imm=0x20 on the fourth edge -> next cycle jb_enable=1, jb_target_pc=0x108, jb_link=0x101.
REQ-024 SHALL cover: src1=0xFFFFFFFF, src2=1 -> blt gives jb_enable=1; bltu gives jb_enable=0; bgeu gives jb_enable=1.
REQ-025 SHALL cover: beq and bne asserted together with equal operands -> jb_enable=1 (beq wins).
REQ-026 SHALL cover, with PC_WORD_ADDR=0: jalr with src1=0x203, imm=1 -> jb_target_pc=0x204, jb_enable=1; with JB_MISALIGN_EXC_EN, jal with D=0x100, imm=0x6 -> misalign_exc=1, jb_enable=0, jb_target_pc=0x106.
REQ-027 SHALL cover: stall=1 for 2 cycles after a taken beq -> jb_enable stays 1 for those cycles, then a flush with stall=1 -> jb_enable=0 next cycle.
REQ-028 SHALL cover: reset_n pulsed low between clock edges while jb_enable=1 -> all outputs 0 immediately; jal with imm=4 issued 3 edges after release -> jb_target_pc=0x1.
